// File: rtl/car_alarm_multizone.sv
// Multi-zone car alarm: arming/entry/alarm sequencing, status LED and an
// immobiliser-style fuel-pump interlock. All outputs are registered.
module car_alarm_multizone #(
  parameter int N_DOORS     = 4,
  parameter int DRIVER_IDX  = 0,
  parameter int T_ARM       = 6,
  parameter int T_DRIVER    = 8,
  parameter int T_PASSENGER = 15,
  parameter int T_SIREN     = 10,
  parameter int BLINK_W     = 2,
  parameter int CNT_W       = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_DOORS-1:0] door_sw,
  input  logic [N_DOORS-1:0] door_mask,
  input  logic               ignition_sw,
  input  logic               hidden_sw,
  input  logic               brake_sw,
  input  logic               panic,
  output logic               system_arm,
  output logic               siren,
  output logic               led,
  output logic               fuel_pump_power,
  output logic [N_DOORS-1:0] trigger_zone
);

  localparam logic [2:0] S_DISARMED   = 3'd0;
  localparam logic [2:0] S_WAIT_OPEN  = 3'd1;
  localparam logic [2:0] S_WAIT_CLOSE = 3'd2;
  localparam logic [2:0] S_ARM_DELAY  = 3'd3;
  localparam logic [2:0] S_ARMED      = 3'd4;
  localparam logic [2:0] S_ENTRY      = 3'd5;
  localparam logic [2:0] S_ALARM      = 3'd6;

  localparam logic [1:0] F_OFF   = 2'd0;
  localparam logic [1:0] F_CRANK = 2'd1;
  localparam logic [1:0] F_RUN   = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] ARM_LAST   = CNT_W'(T_ARM - 1);
  localparam logic [CNT_W-1:0] DRV_LAST   = CNT_W'(T_DRIVER - 1);
  localparam logic [CNT_W-1:0] PAS_LAST   = CNT_W'(T_PASSENGER - 1);
  localparam logic [CNT_W-1:0] SIREN_LAST = CNT_W'(T_SIREN - 1);

  logic [2:0]         state, state_nx;
  logic [1:0]         fuel_state, fuel_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               dsel, dsel_nx;
  logic [N_DOORS-1:0] zone_nx;
  logic [BLINK_W-1:0] blink_cnt, blink_nx;
  logic [N_DOORS-1:0] open_zones;
  logic               open_any;
  logic               drv_open;
  logic [CNT_W-1:0]   entry_last;
  logic               led_nx;

  // Bypassed zones look closed, so a mask change acts in the same cycle.
  assign open_zones = door_sw & ~door_mask;
  assign open_any   = |open_zones;
  assign drv_open   = open_zones[DRIVER_IDX];
  assign entry_last = dsel ? DRV_LAST : PAS_LAST;
  assign blink_nx   = blink_cnt + BLINK_W'(1);

  // NOTE: every variable gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    dsel_nx  = dsel;
    zone_nx  = trigger_zone;

    if (ignition_sw && state != S_ALARM) begin
      state_nx = S_DISARMED;
      cnt_nx   = '0;
      dsel_nx  = 1'b0;
      zone_nx  = '0;
    end else begin
      case (state)
        S_DISARMED: state_nx = S_WAIT_OPEN;

        S_WAIT_OPEN: begin
          if (open_any) state_nx = S_WAIT_CLOSE;
        end

        S_WAIT_CLOSE: begin
          if (!open_any) begin
            state_nx = S_ARM_DELAY;
            cnt_nx   = CNT_ONE;
          end
        end

        S_ARM_DELAY: begin
          if (open_any) begin
            state_nx = S_WAIT_CLOSE;
            cnt_nx   = '0;
          end else if (cnt == ARM_LAST) begin
            state_nx = S_ARMED;
            cnt_nx   = '0;
            zone_nx  = '0;
          end else begin
            cnt_nx = cnt + CNT_ONE;
          end
        end

        S_ARMED: begin
          if (panic) begin
            state_nx = S_ALARM;
            cnt_nx   = '0;
            zone_nx  = open_zones;
          end else if (open_any) begin
            state_nx = S_ENTRY;
            cnt_nx   = CNT_ONE;
            zone_nx  = open_zones;
            dsel_nx  = drv_open;
          end
        end

        S_ENTRY: begin
          zone_nx = trigger_zone | open_zones;
          if (panic) begin
            state_nx = S_ALARM;
            cnt_nx   = '0;
          end else if (dsel && !open_any) begin
            // Driver closing the door inside the delay counts as a valid entry.
            state_nx = S_ARMED;
            cnt_nx   = '0;
            zone_nx  = '0;
          end else if (cnt == entry_last) begin
            cnt_nx = '0;
            if (open_any) begin
              state_nx = S_ALARM;
            end else begin
              state_nx = S_ARMED;
              zone_nx  = '0;
            end
          end else begin
            cnt_nx = cnt + CNT_ONE;
          end
        end

        S_ALARM: begin
          zone_nx = trigger_zone | open_zones;
          if (ignition_sw && hidden_sw) begin
            state_nx = S_DISARMED;
            cnt_nx   = '0;
            zone_nx  = '0;
          end else if (open_any) begin
            cnt_nx = '0;
          end else if (cnt == SIREN_LAST) begin
            state_nx = S_ARMED;
            cnt_nx   = '0;
            zone_nx  = '0;
          end else begin
            cnt_nx = cnt + CNT_ONE;
          end
        end

        default: begin
          state_nx = S_DISARMED;
          cnt_nx   = '0;
          zone_nx  = '0;
        end
      endcase
    end
  end

  always_comb begin
    fuel_nx = fuel_state;
    case (fuel_state)
      F_OFF: begin
        if (ignition_sw) fuel_nx = F_CRANK;
      end
      F_CRANK: begin
        if (!ignition_sw)                fuel_nx = F_OFF;
        else if (brake_sw && hidden_sw)  fuel_nx = F_RUN;
      end
      F_RUN: begin
        if (!ignition_sw) fuel_nx = F_OFF;
      end
      default: fuel_nx = F_OFF;
    endcase
  end

  always_comb begin
    led_nx = 1'b0;
    case (state_nx)
      S_ARM_DELAY, S_ALARM: led_nx = 1'b1;
      S_ARMED, S_ENTRY:     led_nx = blink_nx[BLINK_W-1];
      default:              led_nx = 1'b0;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_DISARMED;
      fuel_state      <= F_OFF;
      cnt             <= '0;
      dsel            <= 1'b0;
      blink_cnt       <= '0;
      trigger_zone    <= '0;
      system_arm      <= 1'b0;
      siren           <= 1'b0;
      led             <= 1'b0;
      fuel_pump_power <= 1'b0;
    end else begin
      state           <= state_nx;
      fuel_state      <= fuel_nx;
      cnt             <= cnt_nx;
      dsel            <= dsel_nx;
      blink_cnt       <= blink_nx;
      trigger_zone    <= zone_nx;
      system_arm      <= (state_nx == S_ARMED) || (state_nx == S_ENTRY) ||
                         (state_nx == S_ALARM);
      siren           <= (state_nx == S_ALARM);
      led             <= led_nx;
      // The fuel FSM keeps running underneath; only the pump drive is gated.
      fuel_pump_power <= (fuel_nx == F_RUN) && (state_nx != S_ALARM);
    end
  end

endmodule

// File: tb/tb_car_alarm_multizone.sv
// Directed bench for car_alarm_multizone: a mode-level behavioural model
// checked every cycle, plus hand-computed literal expectations.
module tb_car_alarm_multizone;

  localparam int N_DOORS     = 4;
  localparam int DRIVER_IDX  = 0;
  localparam int T_ARM       = 6;
  localparam int T_DRIVER    = 8;
  localparam int T_PASSENGER = 15;
  localparam int T_SIREN     = 10;
  localparam int BLINK_W     = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N_DOORS-1:0] door_sw, door_mask;
  logic               ignition_sw, hidden_sw, brake_sw, panic;
  logic               system_arm, siren, led, fuel_pump_power;
  logic [N_DOORS-1:0] trigger_zone;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  car_alarm_multizone #(
    .N_DOORS(N_DOORS), .DRIVER_IDX(DRIVER_IDX), .T_ARM(T_ARM),
    .T_DRIVER(T_DRIVER), .T_PASSENGER(T_PASSENGER), .T_SIREN(T_SIREN),
    .BLINK_W(BLINK_W), .CNT_W(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .door_sw(door_sw), .door_mask(door_mask),
    .ignition_sw(ignition_sw), .hidden_sw(hidden_sw), .brake_sw(brake_sw),
    .panic(panic), .system_arm(system_arm), .siren(siren), .led(led),
    .fuel_pump_power(fuel_pump_power), .trigger_zone(trigger_zone)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: modes plus elapsed-cycle tallies.
  typedef enum {MD_DISARMED, MD_WAIT_OPEN, MD_WAIT_CLOSE, MD_ARMING,
                MD_ARMED, MD_ENTRY, MD_ALARM} mode_t;
  typedef enum {FU_OFF, FU_CRANK, FU_RUN} fuel_t;

  mode_t              m_mode   = MD_DISARMED;
  fuel_t              m_fuel   = FU_OFF;
  int                 m_age    = 0;
  int                 m_quiet  = 0;
  int                 m_edges  = 0;
  bit                 m_drv    = 1'b0;
  logic [N_DOORS-1:0] m_zones  = '0;

  initial forever begin
    logic [N_DOORS-1:0] unmasked;
    bit any_open;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_mode = MD_DISARMED; m_fuel = FU_OFF; m_age = 0; m_quiet = 0;
      m_edges = 0; m_drv = 1'b0; m_zones = '0;
    end else begin
      unmasked = door_sw & ~door_mask;
      any_open = (unmasked != '0);
      m_edges  = m_edges + 1;

      if (m_fuel == FU_OFF && ignition_sw) m_fuel = FU_CRANK;
      else if (m_fuel == FU_CRANK && !ignition_sw) m_fuel = FU_OFF;
      else if (m_fuel == FU_CRANK && brake_sw && hidden_sw) m_fuel = FU_RUN;
      else if (m_fuel == FU_RUN && !ignition_sw) m_fuel = FU_OFF;

      if (m_mode != MD_ALARM && ignition_sw) begin
        m_mode = MD_DISARMED; m_zones = '0;
      end else begin
        case (m_mode)
          MD_DISARMED:   m_mode = MD_WAIT_OPEN;
          MD_WAIT_OPEN:  if (any_open) m_mode = MD_WAIT_CLOSE;
          MD_WAIT_CLOSE: if (!any_open) begin m_mode = MD_ARMING; m_age = 1; end
          MD_ARMING: begin
            if (any_open) m_mode = MD_WAIT_CLOSE;
            else begin
              m_age++;
              if (m_age == T_ARM) begin m_mode = MD_ARMED; m_zones = '0; end
            end
          end
          MD_ARMED: begin
            if (panic) begin
              m_mode = MD_ALARM; m_quiet = 0; m_zones = unmasked;
            end else if (any_open) begin
              m_mode = MD_ENTRY; m_age = 1; m_drv = unmasked[DRIVER_IDX];
              m_zones = unmasked;
            end
          end
          MD_ENTRY: begin
            m_zones |= unmasked;
            if (panic) begin
              m_mode = MD_ALARM; m_quiet = 0;
            end else if (m_drv && !any_open) begin
              m_mode = MD_ARMED; m_zones = '0;
            end else begin
              m_age++;
              if (m_age == (m_drv ? T_DRIVER : T_PASSENGER)) begin
                if (any_open) begin m_mode = MD_ALARM; m_quiet = 0; end
                else begin m_mode = MD_ARMED; m_zones = '0; end
              end
            end
          end
          MD_ALARM: begin
            m_zones |= unmasked;
            if (ignition_sw && hidden_sw) begin
              m_mode = MD_DISARMED; m_zones = '0;
            end else if (any_open) begin
              m_quiet = 0;
            end else begin
              m_quiet++;
              if (m_quiet == T_SIREN) begin m_mode = MD_ARMED; m_zones = '0; end
            end
          end
          default: m_mode = MD_DISARMED;
        endcase
      end
    end
  end

  // Per-cycle comparison, away from the active edge.
  initial forever begin
    bit e_arm, e_siren, e_led, e_pump;
    @(negedge clk);
    e_arm   = (m_mode == MD_ARMED) || (m_mode == MD_ENTRY) || (m_mode == MD_ALARM);
    e_siren = (m_mode == MD_ALARM);
    if (m_mode == MD_ARMING || m_mode == MD_ALARM) e_led = 1'b1;
    else if (m_mode == MD_ARMED || m_mode == MD_ENTRY)
      e_led = ((m_edges >> (BLINK_W - 1)) & 1) != 0;
    else e_led = 1'b0;
    e_pump = (m_fuel == FU_RUN) && (m_mode != MD_ALARM);
    check("model_system_arm", system_arm, e_arm);
    check("model_siren", siren, e_siren);
    check("model_led", led, e_led);
    check("model_pump", fuel_pump_power, e_pump);
    check("model_trigger_zone", trigger_zone, m_zones);
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end before %0t", $time);
    $fatal(1);
  end

  initial begin
    int ones;
    rst_n = 1'b0; door_sw = '0; door_mask = '0;
    ignition_sw = 1'b1; hidden_sw = 1'b0; brake_sw = 1'b0; panic = 1'b0;
    #12;
    check("reset_arm", system_arm, 0);
    check("reset_siren", siren, 0);
    check("reset_led", led, 0);
    check("reset_pump", fuel_pump_power, 0);
    check("reset_zone", trigger_zone, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Arming sequence
    cyc(2);
    ignition_sw = 1'b0; cyc(1);
    door_sw = 4'b0001; cyc(3);
    door_sw = 4'b0000;
    repeat (5) begin
      cyc(1);
      check("arm_delay_led", led, 1);
      check("arm_delay_not_armed", system_arm, 0);
    end
    cyc(1);
    check("armed_after_6", system_arm, 1);
    ones = 0;
    repeat (4) begin cyc(1); ones += int'(led); end
    check("blink_half_duty", ones, 2);

    // Driver entry times out into alarm
    door_sw = 4'b0001; cyc(7);
    check("drv_entry_7_quiet", siren, 0);
    cyc(1);
    check("drv_entry_8_siren", siren, 1);
    check("drv_entry_zone", trigger_zone, 4'b0001);

    // Quiet count restarts when a door reopens
    door_sw = 4'b0000; cyc(6);
    door_sw = 4'b0001; cyc(1);
    door_sw = 4'b0000; cyc(9);
    check("quiet_restart_still_on", siren, 1);
    cyc(1);
    check("quiet_10_siren_off", siren, 0);
    check("quiet_10_rearmed", system_arm, 1);

    // Driver closes inside the delay
    door_sw = 4'b0001; cyc(4);
    door_sw = 4'b0000; cyc(1);
    check("drv_close_armed", system_arm, 1);
    cyc(10);
    check("drv_close_no_siren", siren, 0);

    // Passenger entry expires with doors closed
    door_sw = 4'b0100; cyc(2);
    door_sw = 4'b0000; cyc(12);
    check("pas_entry_quiet", siren, 0);
    cyc(21);
    check("pas_expire_no_siren", siren, 0);
    check("pas_expire_armed", system_arm, 1);

    // Passenger entry with reopen at the last cycle
    door_sw = 4'b0100; cyc(2);
    door_sw = 4'b0000; cyc(11);
    door_sw = 4'b0100; cyc(1);
    check("pas_cycle14_quiet", siren, 0);
    cyc(1);
    check("pas_cycle15_siren", siren, 1);
    check("pas_zone", trigger_zone, 4'b0100);

    // Ignition alone does not disarm; hidden switch does
    door_sw = 4'b0000; ignition_sw = 1'b1; brake_sw = 1'b1; hidden_sw = 1'b0; cyc(3);
    check("ign_alone_siren", siren, 1);
    check("alarm_pump_off", fuel_pump_power, 0);
    hidden_sw = 1'b1; cyc(1);
    check("disarm_siren", siren, 0);
    check("disarm_arm", system_arm, 0);
    check("pump_on", fuel_pump_power, 1);
    hidden_sw = 1'b0; cyc(2);
    check("pump_held", fuel_pump_power, 1);
    ignition_sw = 1'b0; brake_sw = 1'b0; cyc(1);
    check("pump_drop", fuel_pump_power, 0);

    // Panic outside armed states is ignored
    panic = 1'b1; cyc(3);
    check("panic_ignored", siren, 0);
    panic = 1'b0;

    // Re-arm with an abort during the delay
    door_sw = 4'b0010; cyc(1);
    door_sw = 4'b0000; cyc(3);
    door_sw = 4'b0010; cyc(1);
    check("arm_abort_led", led, 0);
    door_sw = 4'b0000; cyc(5);
    check("rearm_pending", system_arm, 0);
    cyc(1);
    check("rearm_done", system_arm, 1);

    // Masked zone is invisible; unmasking triggers entry at once
    door_mask = 4'b0010; door_sw = 4'b0010; cyc(20);
    check("mask_no_entry_siren", siren, 0);
    check("mask_no_zone", trigger_zone, 4'b0000);
    door_mask = 4'b0000; cyc(1);
    check("unmask_zone", trigger_zone, 4'b0010);
    door_sw = 4'b0000; cyc(14);
    panic = 1'b1; cyc(1);
    check("panic_armed_siren", siren, 1);
    panic = 1'b0;
    ignition_sw = 1'b1; hidden_sw = 1'b1; cyc(1);
    check("panic_disarm", siren, 0);
    ignition_sw = 1'b0; hidden_sw = 1'b0; cyc(1);

    // Asynchronous reset in the middle of an alarm
    door_sw = 4'b0001; cyc(1);
    door_sw = 4'b0000; cyc(6);
    panic = 1'b1; cyc(1);
    check("pre_reset_siren", siren, 1);
    panic = 1'b0; cyc(2);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_siren", siren, 0);
    check("async_reset_arm", system_arm, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
